// File: rtl/router_output_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | router_output_arbiter                                                     |
// | Per-output-port scheduler. Polarity alternates fill/drain between 2 VCs.  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module router_output_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          polarity_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic                          so_o,
  input  logic                          ro_i,
  output logic [DATA_WIDTH-1:0]         do_o
);

  localparam int PTR_W = 2;

  logic [1:0][DATA_WIDTH-1:0] buf_data_q, buf_data_d;
  logic [1:0]                 buf_full_q, buf_full_d;
  logic [1:0][PTR_W-1:0]      rr_ptr_q, rr_ptr_d;

  logic               fill_vc;
  logic               drain_vc;
  logic [NUM_REQ-1:0] elig;
  logic               found;
  logic [PTR_W-1:0]   win;
  logic [PTR_W-1:0]   idx;

  assign fill_vc  = ~polarity_i;
  assign drain_vc = polarity_i;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_i[i] & (req_data_i[i*DATA_WIDTH + DATA_WIDTH - 1] == fill_vc);
    end
  end

  // Grants are suppressed while reset is held so gnt falls with so/do.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    if (rst_ni && !buf_full_q[fill_vc]) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = rr_ptr_q[fill_vc] + PTR_W'(k);
        if (!found && elig[idx]) begin
          found = 1'b1;
          win   = idx;
        end
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (found) begin
      gnt_o[win] = 1'b1;
    end
  end

  always_comb begin
    buf_data_d = buf_data_q;
    buf_full_d = buf_full_q;
    rr_ptr_d   = rr_ptr_q;
    if (found) begin
      buf_data_d[fill_vc] = req_data_i[win*DATA_WIDTH +: DATA_WIDTH];
      buf_full_d[fill_vc] = 1'b1;
      rr_ptr_d[fill_vc]   = win + 2'd1;
    end
    if (buf_full_q[drain_vc] && ro_i) begin
      buf_full_d[drain_vc] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_data_q <= '0;
      buf_full_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      buf_data_q <= buf_data_d;
      buf_full_q <= buf_full_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // Drained entries keep their data, so do_o shows stale flits while so_o=0.
  assign so_o = buf_full_q[drain_vc];
  assign do_o = buf_data_q[drain_vc];

endmodule
`default_nettype wire

// File: tb/tb_router_output_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_router_output_arbiter                                                  |
// | Directed self-checking bench for router_output_arbiter.                   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_router_output_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             polarity;
  logic [3:0]       req;
  logic [3:0][63:0] rd;
  logic [3:0]       gnt;
  logic             so;
  logic             ro;
  logic [63:0]      dout;

  int n_tests = 0;
  int n_fail  = 0;

  router_output_arbiter #(.DATA_WIDTH(64), .NUM_REQ(4)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .polarity_i (polarity),
    .req_i      (req),
    .req_data_i (rd),
    .gnt_o      (gnt),
    .so_o       (so),
    .ro_i       (ro),
    .do_o       (dout)
  );

  always #5 clk = ~clk;

  // Advance one clock; polarity flips just after each rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    polarity = ~polarity;
  endtask

  // Leaves the bench in a polarity=0 cycle just after reset release.
  task automatic do_reset();
    rst_n = 1'b0; req = '0; rd = '0; ro = 1'b1; polarity = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ro = 1'b1; polarity = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) rd[i] = {1'b1, 63'(i + 1)};
    @(posedge clk); #2;
    n_tests++; if (so !== 1'b0) begin n_fail++; $display("FAIL reset_so: got %0b exp 0", so); end
    n_tests++; if (dout !== 64'h0) begin n_fail++; $display("FAIL reset_do: got %h exp 0", dout); end
    n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b exp 0000", gnt); end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100; rd[2] = 64'h8000_0000_1111_1111; #1;
    n_tests++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt: got %b exp 0100", gnt); end
    cyc(); req = '0; #1;
    n_tests++; if (so !== 1'b1 || dout !== 64'h8000_0000_1111_1111) begin
      n_fail++; $display("FAIL single_send: so=%0b do=%h exp so=1 do=8000000011111111", so, dout); end
    cyc(); cyc(); #1;
    n_tests++; if (so !== 1'b0 || dout !== 64'h8000_0000_1111_1111) begin
      n_fail++; $display("FAIL single_drained: so=%0b do=%h exp so=0 do=8000000011111111", so, dout); end
    cyc();
    req = 4'b1001; rd[0] = 64'h8000_0000_AAAA_AAAA; rd[3] = 64'h8000_0000_BBBB_BBBB; #1;
    n_tests++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL single_ptr3: got %b exp 1000", gnt); end
    cyc(); req = '0; #1;
    n_tests++; if (dout !== 64'h8000_0000_BBBB_BBBB) begin
      n_fail++; $display("FAIL single_ptr3_data: got %h exp 80000000bbbbbbbb", dout); end
  endtask

  task automatic test_round_robin();
    logic [63:0] exp_d;
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 4; i++) rd[i] = 64'h0000_0000_A000_0000 | 64'(i);
    #1;
    n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rr_wrong_phase: got %b exp 0000", gnt); end
    for (int k = 0; k < 5; k++) begin
      cyc(); #1;
      n_tests++; if (gnt !== (4'b0001 << (k % 4))) begin
        n_fail++; $display("FAIL rr_gnt%0d: got %b exp %b", k, gnt, 4'b0001 << (k % 4)); end
      exp_d = rd[k % 4];
      cyc();
      rd[k % 4] = rd[k % 4] + 64'h10;
      #1;
      n_tests++; if (so !== 1'b1 || dout !== exp_d) begin
        n_fail++; $display("FAIL rr_do%0d: so=%0b do=%h exp so=1 do=%h", k, so, dout, exp_d); end
    end
    req = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    cyc();
    req = 4'b0001; rd[0] = 64'h0000_0000_F1F1_F1F1; #1;
    n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL bp_first_gnt: got %b exp 0001", gnt); end
    cyc();
    req = 4'b0010; rd[1] = 64'h0000_0000_F2F2_F2F2; ro = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_tests++; if (gnt[1] !== 1'b0) begin n_fail++; $display("FAIL bp_hold_gnt%0d: got %b exp 0", c, gnt[1]); end
      if (polarity == 1'b0) begin
        n_tests++; if (so !== 1'b1 || dout !== 64'h0000_0000_F1F1_F1F1) begin
          n_fail++; $display("FAIL bp_hold_so%0d: so=%0b do=%h exp so=1 do=00000000f1f1f1f1", c, so, dout); end
      end
      cyc();
    end
    ro = 1'b1; #1;
    n_tests++; if (so !== 1'b1 || dout !== 64'h0000_0000_F1F1_F1F1) begin
      n_fail++; $display("FAIL bp_release: so=%0b do=%h exp so=1", so, dout); end
    cyc(); #1;
    n_tests++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL bp_after_gnt: got %b exp 0010", gnt); end
    cyc(); req = '0;
  endtask

  task automatic test_vc_sep();
    do_reset();
    req = 4'b1001; rd[0] = 64'h0000_0000_2222_2222; rd[3] = 64'h8000_0000_3333_3333; #1;
    n_tests++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL vc_gnt_vc1: got %b exp 1000", gnt); end
    cyc(); req = 4'b0001; #1;
    n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL vc_gnt_vc0: got %b exp 0001", gnt); end
    n_tests++; if (so !== 1'b1 || dout !== 64'h8000_0000_3333_3333) begin
      n_fail++; $display("FAIL vc_do_vc1: so=%0b do=%h exp so=1 do=8000000033333333", so, dout); end
    cyc(); req = '0; #1;
    n_tests++; if (so !== 1'b1 || dout !== 64'h0000_0000_2222_2222) begin
      n_fail++; $display("FAIL vc_do_vc0: so=%0b do=%h exp so=1 do=0000000022222222", so, dout); end
    n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL vc_idle_gnt: got %b exp 0000", gnt); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    ro = 1'b0;
    req = 4'b1001; rd[0] = 64'h0000_0000_2222_2222; rd[3] = 64'h8000_0000_3333_3333;
    cyc(); req = 4'b0001;
    cyc();
    req = 4'b0111; rd[0] = 64'h0000_0000_4444_4444; rd[1] = 64'h0000_0000_5555_5555;
    rd[2] = 64'h8000_0000_6666_6666; #1;
    n_tests++; if (so !== 1'b1 || gnt !== 4'b0000) begin
      n_fail++; $display("FAIL mr_full: so=%0b gnt=%b exp so=1 gnt=0000", so, gnt); end
    rst_n = 1'b0; #1;
    n_tests++; if (so !== 1'b0 || dout !== 64'h0 || gnt !== 4'b0000) begin
      n_fail++; $display("FAIL mr_async: so=%0b do=%h gnt=%b exp all 0", so, dout, gnt); end
    #4; rst_n = 1'b1; ro = 1'b1; #1;
    n_tests++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL mr_vc1_gnt: got %b exp 0100", gnt); end
    cyc(); req = 4'b0011; #1;
    n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL mr_vc0_gnt: got %b exp 0001", gnt); end
    cyc(); req = '0;
  endtask

  initial begin
    rst_n = 1'b0; polarity = 1'b0; req = '0; rd = '0; ro = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_vc_sep();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/router_output_arbiter.md
Name: router_output_arbiter

Overview:
- Per-output-port scheduler for the mesh router. Shares one outgoing link (E, W, N, S or PE) among 4 requesting input channels.
- Holds one flit per virtual channel (VC0/VC1) in a local output buffer.
- Uses the global polarity phase to alternate between internal fill (arbitration) and external drain (link transmit) per VC.
- Round-robin fairness is kept per VC; flits pass through unmodified.

Parameters:
- DATA_WIDTH, 64, flit width; bit DATA_WIDTH-1 is the VC bit.
- NUM_REQ, 4, number of requesting input channels; fixed at 4, and the pointer is 2 bits.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- polarity  input  1  global phase; toggles every cycle, shared by all routers.
- req  input  NUM_REQ  per-requester flit-valid.
- req_data  input  NUM_REQ*DATA_WIDTH  flattened flits; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- gnt  output  NUM_REQ  one-hot grant; requester i drops or advances its flit on the edge where gnt[i]=1.
- so  output  1  send-out valid toward the downstream router or PE.
- ro  input  1  downstream ready (downstream buffer for the current VC is empty).
- do  output  DATA_WIDTH  flit toward downstream.

Behaviour:
- State:
  - buf_data[0:1] and buf_full[0:1], one entry per VC.
  - rr_ptr[0:1], 2-bit round-robin pointer per VC.
- Reset (reset=0, asynchronous): buf_full=0, buf_data=0, rr_ptr=0. As a result so=0, do=0, gnt=0.
- Phase split, each cycle:
  - Fill VC f = ~polarity.
  - Drain VC d = polarity.
  - Fill and drain never touch the same VC in a cycle, so no read/write conflict exists.
- Fill (arbitration, combinational gnt):
  - Eligible requester i: req[i]=1 and req_data_i[MSB]==f.
  - If buf_full[f]=0 and at least one requester is eligible, grant the first eligible index searching rr_ptr[f], rr_ptr[f]+1, ... modulo 4. Exactly one gnt bit is high.
  - If buf_full[f]=1 or none is eligible, gnt=0.
  - On a clock edge with a grant to winner w:
    - buf_data[f] <= req_data_w
    - buf_full[f] <= 1
    - rr_ptr[f] <= w+1 (wraps 3->0)
  - rr_ptr[d] is unchanged that cycle.
  - Requesters whose VC bit is not f are ignored and receive no grant; they are eligible on the next phase.
- Drain:
  - so = buf_full[d] (combinational from registers); do = buf_data[d].
  - On a clock edge with so=1 and ro=1: buf_full[d] <= 0. buf_data is retained, so do still shows stale data with so=0.
  - If ro=0, the flit is held and so stays high whenever polarity returns to d.
- Latency:
  - A granted flit is transmitted on the cycle when polarity equals its VC: normally the next cycle after the grant edge, provided ro=1.
  - Throughput is 1 flit per VC per 2 cycles, 1 flit per cycle aggregate.
- Full buffer with ro=0 indefinitely: no grants on that VC; requesters must hold req/req_data stable until granted.
- req deasserted in the same cycle a grant would be issued: no grant (eligibility is evaluated combinationally).
- Reset asserted mid-operation: buffered flits are discarded and pointers return to 0. No partial transmit occurs, since so drops immediately.
- No field of the flit (VC, dir, hop, source, payload) is modified; hop bookkeeping belongs to the input side.

Test Plan:
- Reset, then 1 request:
  - Stimulus: release reset; in the cycle with polarity=0, assert req[2]=1 with data 64'h8000_0000_1111_1111 (VC1).
  - Required response: gnt=4'b0100 that cycle. Next cycle (polarity=1) so=1, do=64'h8000_0000_1111_1111; with ro=1, so=0 after that edge. rr_ptr[1]=3.
- Round-robin:
  - Stimulus: all 4 requesters hold VC0 flits A0..A3, ro=1 throughout.
  - Required response: grants in order 0,1,2,3 on successive polarity=1 cycles. do sequence is A0,A1,A2,A3, each on the following polarity=0 cycle. After rr_ptr[0] wraps to 0, requester 0 is granted next.
- Backpressure:
  - Stimulus: VC0 flit buffered, ro=0 for 6 cycles, req[1] holding a second VC0 flit.
  - Required response: so=1 on every polarity=0 cycle, with do unchanged; gnt[1]=0 throughout. When ro=1, the buffer drains, and on the next polarity=1 cycle gnt[1]=1.
- VC separation:
  - Stimulus: req[0] VC0 flit 64'h0000_0000_2222_2222 and req[3] VC1 flit 64'h8000_0000_3333_3333, both held.
  - Required response: req[3] is granted on the polarity=0 cycle and req[0] on the polarity=1 cycle. The VC1 flit appears on do when polarity=1, the VC0 flit when polarity=0. No cycle shows two grants.
- Mid-operation reset:
  - Stimulus: both buffers full, ro=0; pulse reset low for a half cycle.
  - Required response: so=0, do=0 and gnt=0 immediately, without waiting for a clock edge. After release, the first VC0 request granted is the lowest eligible index starting from 0.
